// File: rtl/subword_op_pkg.sv
// ---------------------------------------------------------------------------
// subword_op_pkg
//   Shared CPU constants for the sub-word memory datapath: field widths and
//   the layout of the lane control words driven by the multi-cycle decoder.
//   Control words are {sign, write, idx}: sign is the MSB, write is MSB-1,
//   and the remaining low bits select the byte/halfword within the word.
// ---------------------------------------------------------------------------
package subword_op_pkg;

   localparam int BYTE = 8;
   localparam int HALF = 16;
   localparam int WORD = 32;

   localparam int BYTE_CTL_W = 4;   // {sign, write, idx[1:0]}
   localparam int HALF_CTL_W = 3;   // {sign, write, idx}

   localparam int BYTE_SIGN  = BYTE_CTL_W - 1;
   localparam int BYTE_WRITE = BYTE_CTL_W - 2;
   localparam int HALF_SIGN  = HALF_CTL_W - 1;
   localparam int HALF_WRITE = HALF_CTL_W - 2;

   // Packed views of the control words; field order matches the bit
   // positions above, so a plain cast from the raw control bus is exact.
   typedef struct packed {
      logic       sign;
      logic       write;
      logic [1:0] idx;
   } byte_ctl_t;

   typedef struct packed {
      logic sign;
      logic write;
      logic idx;
   } half_ctl_t;

endpackage

// File: rtl/subword_op_byte.sv
// ---------------------------------------------------------------------------
// byte_op
//   Byte lane of the sub-word datapath (combinational).
//   Load  (write=0): result = selected byte of word, sign- or zero-extended.
//   Store (write=1): result = word with the selected byte replaced by data.
//   Ports:
//     word   [31:0] in  memory word (little-endian, byte k = word[8k+7:8k])
//     ctl    [3:0]  in  {sign, write, idx[1:0]}
//     data   [7:0]  in  store byte
//     result [31:0] out lane result
// ---------------------------------------------------------------------------
module byte_op
   import subword_op_pkg::*;
(
   input  logic [WORD-1:0]       word,
   input  logic [BYTE_CTL_W-1:0] ctl,
   input  logic [BYTE-1:0]       data,
   output logic [WORD-1:0]       result
);

   byte_ctl_t       c;
   logic [BYTE-1:0] sel;
   logic [WORD-1:0] ext;
   logic [WORD-1:0] merged;

   assign c = byte_ctl_t'(ctl);

   // Select mux: idx scaled by 8 picks the byte lane.
   assign sel = word[{c.idx, 3'b000} +: BYTE];

   // Extend mux.
   assign ext = c.sign ? {{(WORD-BYTE){sel[BYTE-1]}}, sel}
                       : {{(WORD-BYTE){1'b0}}, sel};

   // Merge mux: old word with one byte overwritten.
   always_comb begin
      // NOTE: start from a full default so every bit is assigned on every
      // path; a partial assignment here would infer a latch.
      merged = word;
      merged[{c.idx, 3'b000} +: BYTE] = data;
   end

   assign result = c.write ? merged : ext;

endmodule

// File: rtl/subword_op_half.sv
// ---------------------------------------------------------------------------
// half_op
//   Halfword lane of the sub-word datapath (combinational).
//   Load  (write=0): result = selected halfword, sign- or zero-extended.
//   Store (write=1): result = word with the selected halfword replaced.
//   There is no alignment check: the decoder passes addr[1] as idx.
//   Ports:
//     word   [31:0] in  memory word (little-endian, half k = word[16k+15:16k])
//     ctl    [2:0]  in  {sign, write, idx}
//     data   [15:0] in  store halfword
//     result [31:0] out lane result
// ---------------------------------------------------------------------------
module half_op
   import subword_op_pkg::*;
(
   input  logic [WORD-1:0]       word,
   input  logic [HALF_CTL_W-1:0] ctl,
   input  logic [HALF-1:0]       data,
   output logic [WORD-1:0]       result
);

   half_ctl_t       c;
   logic [HALF-1:0] sel;
   logic [WORD-1:0] ext;
   logic [WORD-1:0] merged;

   assign c = half_ctl_t'(ctl);

   // Select mux.
   assign sel = c.idx ? word[WORD-1:HALF] : word[HALF-1:0];

   // Extend mux.
   assign ext = c.sign ? {{(WORD-HALF){sel[HALF-1]}}, sel}
                       : {{(WORD-HALF){1'b0}}, sel};

   // Merge mux: keep the untouched half, replace the targeted one.
   assign merged = c.idx ? {data, word[HALF-1:0]}
                         : {word[WORD-1:HALF], data};

   assign result = c.write ? merged : ext;

endmodule

// File: rtl/subword_op.sv
// ---------------------------------------------------------------------------
// subword_op
//   Sub-word load/store datapath for the multi-cycle core's memory stages.
//   Holds one byte lane and one halfword lane, both fed from the same memory
//   word; the lanes are independent and may be active together. There is no
//   state: reset simply forces both results to zero while asserted.
//   Ports:
//     clk          in   clock (harness only, nothing is clocked)
//     reset        in   asynchronous, active-high; zeroes both outputs
//     mem_word     in   [31:0] memory word latched by the decoder
//     byte_ctl     in   [3:0]  {sign, write, idx[1:0]}
//     byte_data    in   [7:0]  store byte (rt[7:0])
//     byte_result  out  [31:0] byte-lane result
//     half_ctl     in   [2:0]  {sign, write, idx}
//     half_data    in   [15:0] store halfword (rt[15:0])
//     half_result  out  [31:0] half-lane result
// ---------------------------------------------------------------------------
module subword_op
   import subword_op_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WORD-1:0]       mem_word,
   input  logic [BYTE_CTL_W-1:0] byte_ctl,
   input  logic [BYTE-1:0]       byte_data,
   output logic [WORD-1:0]       byte_result,
   input  logic [HALF_CTL_W-1:0] half_ctl,
   input  logic [HALF-1:0]       half_data,
   output logic [WORD-1:0]       half_result
);

   logic [WORD-1:0] byte_lane;
   logic [WORD-1:0] half_lane;

   // The clock only exists for the common harness.
   logic unused_clk;
   assign unused_clk = clk;

   byte_op u_byte_op (
      .word   (mem_word),
      .ctl    (byte_ctl),
      .data   (byte_data),
      .result (byte_lane)
   );

   half_op u_half_op (
      .word   (mem_word),
      .ctl    (half_ctl),
      .data   (half_data),
      .result (half_lane)
   );

   // Reset gating is a plain combinational AND, so it takes effect the
   // moment reset rises and vanishes the moment it falls.
   assign byte_result = reset ? '0 : byte_lane;
   assign half_result = reset ? '0 : half_lane;

endmodule

// File: tb/tb_subword_op.sv
// ---------------------------------------------------------------------------
// tb_subword_op
//   Scoreboard bench for subword_op. Stimulus drives inputs just after a
//   rising edge and pushes the expected pair of results; a monitor pops and
//   compares on every falling edge. Expected values come either from the
//   literal values worked out by hand or from a byte/halfword array model.
// ---------------------------------------------------------------------------
module tb_subword_op;

   logic        clk;
   logic        reset;
   logic [31:0] mem_word;
   logic [3:0]  byte_ctl;
   logic [7:0]  byte_data;
   logic [31:0] byte_result;
   logic [2:0]  half_ctl;
   logic [15:0] half_data;
   logic [31:0] half_result;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] exp_b;
      logic [31:0] exp_h;
   } exp_t;

   exp_t exp_q[$];

   subword_op dut (
      .clk         (clk),
      .reset       (reset),
      .mem_word    (mem_word),
      .byte_ctl    (byte_ctl),
      .byte_data   (byte_data),
      .byte_result (byte_result),
      .half_ctl    (half_ctl),
      .half_data   (half_data),
      .half_result (half_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Reference model: split the word into an array of bytes, then either
   // overwrite one element or read one element and extend it numerically.
   function automatic logic [31:0] ref_byte(input logic [31:0] w, input logic [3:0] ctl,
                                            input logic [7:0] d);
      logic [7:0] b [4];
      int idx;
      int v;
      for (int k = 0; k < 4; k++) b[k] = 8'((w >> (8 * k)) & 32'hFF);
      idx = int'(ctl[1:0]);
      if (ctl[2]) begin
         b[idx] = d;
         return {b[3], b[2], b[1], b[0]};
      end
      v = int'(b[idx]);
      if (ctl[3] && v >= 128) v -= 256;
      return 32'(v);
   endfunction

   function automatic logic [31:0] ref_half(input logic [31:0] w, input logic [2:0] ctl,
                                            input logic [15:0] d);
      logic [15:0] h [2];
      int idx;
      int v;
      for (int k = 0; k < 2; k++) h[k] = 16'((w >> (16 * k)) & 32'hFFFF);
      idx = int'(ctl[0]);
      if (ctl[1]) begin
         h[idx] = d;
         return {h[1], h[0]};
      end
      v = int'(h[idx]);
      if (ctl[2] && v >= 32768) v -= 65536;
      return 32'(v);
   endfunction

   // Drive one transaction. A lane's expectation is the literal supplied
   // when use_x is set, otherwise the model's value.
   task automatic apply(input string name, input logic [31:0] w,
                        input logic [3:0] bc, input logic [7:0] bd,
                        input logic [2:0] hc, input logic [15:0] hd,
                        input bit use_b, input logic [31:0] lit_b,
                        input bit use_h, input logic [31:0] lit_h);
      exp_t e;
      @(posedge clk);
      mem_word  = w;
      byte_ctl  = bc;
      byte_data = bd;
      half_ctl  = hc;
      half_data = hd;
      e.name  = name;
      e.exp_b = use_b ? lit_b : ref_byte(w, bc, bd);
      e.exp_h = use_h ? lit_h : ref_half(w, hc, hd);
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d entries left expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Monitor: outputs are combinational, so a falling-edge sample sees the
   // response to inputs driven just after the preceding rising edge.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check({e.name, "_byte"}, byte_result, e.exp_b);
         check({e.name, "_half"}, half_result, e.exp_h);
      end
   end

   initial begin
      logic [31:0] w;
      logic [3:0]  bc;
      logic [2:0]  hc;

      // Reset asserted from time zero with nonzero-producing inputs.
      reset     = 1'b1;
      mem_word  = 32'hA1B2_C3D4;
      byte_ctl  = 4'b1000;
      byte_data = 8'h00;
      half_ctl  = 3'b101;
      half_data = 16'h0000;
      #2;
      check("reset_byte", byte_result, 32'h0);
      check("reset_half", half_result, 32'h0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Directed loads.
      apply("ld_b0s_h0u", 32'hA1B2_C3D4, 4'b1000, 8'h00, 3'b000, 16'h0000,
            1, 32'hFFFF_FFD4, 1, 32'h0000_C3D4);
      apply("ld_b2u_h1s", 32'hA1B2_C3D4, 4'b0010, 8'h00, 3'b101, 16'h0000,
            1, 32'h0000_00B2, 1, 32'hFFFF_A1B2);
      apply("ld_pos_sign", 32'h7F00_0000, 4'b1011, 8'h00, 3'b101, 16'h0000,
            1, 32'h0000_007F, 1, 32'h0000_7F00);
      apply("idle", 32'hA1B2_C3D4, 4'b0000, 8'h00, 3'b000, 16'h0000,
            1, 32'h0000_00D4, 1, 32'h0000_C3D4);

      // Store merge on both lanes in the same cycle; byte sign bit ignored.
      apply("st_both", 32'hA1B2_C3D4, 4'b1101, 8'h5E, 3'b011, 16'h1234,
            1, 32'hA1B2_5ED4, 1, 32'h1234_C3D4);

      // Store sweep on an all-ones word clearing one field at a time.
      apply("sw_b0_h0", 32'hFFFF_FFFF, 4'b0100, 8'h00, 3'b010, 16'h0000,
            1, 32'hFFFF_FF00, 1, 32'hFFFF_0000);
      apply("sw_b1_h1", 32'hFFFF_FFFF, 4'b0101, 8'h00, 3'b011, 16'h0000,
            1, 32'hFFFF_00FF, 1, 32'h0000_FFFF);
      apply("sw_b2", 32'hFFFF_FFFF, 4'b0110, 8'h00, 3'b000, 16'h0000,
            1, 32'hFF00_FFFF, 1, 32'h0000_FFFF);
      apply("sw_b3", 32'hFFFF_FFFF, 4'b0111, 8'h00, 3'b000, 16'h0000,
            1, 32'h00FF_FFFF, 1, 32'h0000_FFFF);

      // Randomized transactions against the array model.
      for (int i = 0; i < 200; i++) begin
         w  = $urandom;
         bc = 4'($urandom_range(0, 15));
         hc = 3'($urandom_range(0, 7));
         apply("rand", w, bc, 8'($urandom_range(0, 255)), hc,
               16'($urandom_range(0, 65535)), 0, 32'h0, 0, 32'h0);
      end
      drain();

      // Asynchronous reset mid-cycle, between clock edges.
      apply("pre_reset", 32'hA1B2_C3D4, 4'b1000, 8'h00, 3'b101, 16'h0000,
            1, 32'hFFFF_FFD4, 1, 32'hFFFF_A1B2);
      drain();
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("async_rst_byte", byte_result, 32'h0);
      check("async_rst_half", half_result, 32'h0);
      #1 reset = 1'b0;
      #1;
      check("rst_release_byte", byte_result, 32'hFFFF_FFD4);
      check("rst_release_half", half_result, 32'hFFFF_A1B2);

      @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/subword_op.md
# subword_op

Combinational sub-word datapath for the multi-cycle MIPS core's memory stages. It contains a byte lane (`byte_op`) and a halfword lane (`half_op`). On loads, each lane extracts a byte or halfword from a 32-bit memory word and sign- or zero-extends it. On stores, each lane merges register data into the old memory word, so `sb`/`sh` can be done as read-modify-write of a full word. The decoder drives both lanes from the word latched in MEMRD and uses their results in MEMWB (load) and MEMWR (store).

## Interface
- No parameters.
- `clk`  input  1  clock; only present for the common reset/clock harness, no state is clocked.
- `reset`  input  1  reset, asynchronous, active-high.
- `mem_word`  input  32  memory word; shared by both lanes.
- `byte_ctl`  input  4  byte-lane control, `{sign, write, idx[1:0]}`.
- `byte_data`  input  8  store byte, taken from rt[7:0].
- `byte_result`  output  32  byte-lane result.
- `half_ctl`  input  3  half-lane control, `{sign, write, idx}`.
- `half_data`  input  16  store halfword, taken from rt[15:0].
- `half_result`  output  32  half-lane result.

## Operation
- Byte order is little-endian:
  - byte idx k occupies `mem_word[8k+7:8k]`;
  - half idx k occupies `mem_word[16k+15:16k]`.
- Load mode (`write=0`):
  - the result is the selected field, extended to 32 bits;
  - `sign=1` sign-extends from the field's top bit;
  - `sign=0` zero-extends.
- Store mode (`write=1`):
  - the result is `mem_word` with the selected field replaced by `byte_data` or `half_data`;
  - all other bits pass through unchanged;
  - `sign` is ignored.
- The decoder encodes controls as follows:
  - load: `{is_signed_load, 0, addr[1:0]}` (byte lane) or `{is_signed_load, 0, addr[1]}` (half lane);
  - store: `{0, 1, addr}`;
  - idle: all zeros. Idle control makes the lane output the zero-extended byte 0 or half 0; the result is don't-care to the consumer.
- Alignment: there is no halfword alignment fault. `addr[0]` is not an input, so an odd-address halfword uses idx `addr[1]`.
- The two lanes are fully independent and may be active in the same cycle.
- Reset:
  - while `reset=1`, both outputs are forced to `32'h0` immediately, with no clock needed;
  - when reset is released, the outputs follow their inputs again combinationally.

## Timing
- Purely combinational, zero-cycle latency: outputs settle in the same cycle the inputs change.
- There is no handshake and no internal state, so there are no full/empty or wrap-around conditions.
- Reset acts asynchronously:
  - asserting it mid-operation zeroes the outputs at once;
  - no history survives deassertion.
- Upstream timing: the decoder latches `mem_word` one state before use, so the consumer samples the result on its next clock edge.

## Structure
- The shared CPU package holds:
  - lane control bit positions: `SIGN` = MSB, `WRITE` = MSB-1, then idx;
  - the widths BYTE=8, HALF=16, WORD=32.
- Sub-modules `byte_op` and `half_op`:
  - each is combinational;
  - each lane's ports are word, ctl, data, result;
  - each contains a select mux, an extend mux and a merge mux.
- The top-level `subword_op` instantiates one of each and applies the reset gating.

## Test plan
- `mem_word=A1B2C3D4`, `byte_ctl=1000` (signed load, idx 0) → `byte_result=FFFFFFD4`. Then `byte_ctl=0010` (unsigned load, idx 2) → `000000B2`.
- `mem_word=7F000000`, `byte_ctl=1011` (signed load, idx 3) → `0000007F`; confirms positive sign-extension.
- `mem_word=A1B2C3D4`, `half_ctl=101` (signed load, idx 1) → `FFFFA1B2`. Then `half_ctl=000` (unsigned load, idx 0) → `0000C3D4`.
- Store merge:
  - `byte_ctl=1101` (sign bit set, must be ignored), `byte_data=5E` → `A1B25ED4`;
  - `half_ctl=011`, `half_data=1234` → `1234C3D4`;
  - both lanes driven in the same cycle and checked simultaneously.
- Sweep all 4 byte idx and both half idx in store mode with `mem_word=FFFFFFFF` and data 00 → only the targeted field clears in each case.
- Assert `reset` with a nonzero result present → both outputs become `0` with no clock edge. Release `reset` → the prior values reappear.
